serial_add_sub_unit: RTL and testbench

- Parametrised bit-serial adder/subtractor.
- Processes two WIDTH-bit operands LSB-first, one bit per clock, through a single 1-bit full-adder cell and a carry flip-flop.
- Generalises the single-bit combinational full adder to arbitrary width, adds a subtract mode, and provides signed-overflow detection plus a start/busy/done handshake.
- Sits between the lab switch/button front end and the display/LED back end.

---
 rtl/add_sub_pkg.sv | 14 +
 rtl/serial_fa_cell.sv | 14 +
 rtl/serial_add_sub_unit.sv | 112 +++++++++++
 tb/tb_serial_add_sub_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding and operation mode constants.
package add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit combinational full adder; the only arithmetic element of
// the serial unit, reused once per clock for each operand bit.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub_unit.sv
// Bit-serial adder/subtractor. Operands are consumed LSB-first, one bit
// per clock, through one full-adder cell and a carry flip-flop. Subtract
// is done as a + ~b + 1 by inverting b at load and presetting the carry.
module serial_add_sub_unit
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic             bit_s;
  logic             carry_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             last_bit_s;

  serial_fa_cell u_cell (
    .a   (op_a_r[0]),
    .b   (op_b_r[0]),
    .cin (carry_r),
    .s   (bit_s),
    .co  (carry_s)
  );

  // Result word after shifting the current sum bit in from the MSB side.
  always_comb begin
    acc_next_s            = acc_r >> 1'b1;
    acc_next_s[WIDTH-1]   = bit_s;
  end

  assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

  // Control FSM with datapath registers and registered outputs. In the
  // last bit, carry_r still holds the carry into the MSB, so overflow is
  // formed from it and the cell's carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      op_a_r   <= '0;
      op_b_r   <= '0;
      acc_r    <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a_r  <= a;
            op_b_r  <= b ^ {WIDTH{mode}};
            carry_r <= (mode == MODE_SUB) ? 1'b1 : 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          carry_r <= carry_s;
          op_a_r  <= op_a_r >> 1'b1;
          op_b_r  <= op_b_r >> 1'b1;
          acc_r   <= acc_next_s;
          cnt_r   <= cnt_r + CW'(1'b1);
          if (last_bit_s) begin
            sum      <= acc_next_s;
            cout     <= carry_s;
            overflow <= carry_r ^ carry_s;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            busy     <= 1'b1;
            done     <= 1'b0;
            state_r  <= ST_RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Scoreboard bench for the serial adder/subtractor: stimulus pushes the
// expected {cout, overflow, sum} into a queue, monitors pop on done.
module tb_serial_add_sub_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8 instance
  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, cout8, ovf8;
  // WIDTH=1 instance
  logic       start1 = 1'b0, mode1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       busy1, done1, cout1, ovf1;
  // WIDTH=16 instance
  logic        start16 = 1'b0, mode16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        busy16, done16, cout16, ovf16;

  serial_add_sub_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));
  serial_add_sub_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));
  serial_add_sub_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16));

  logic [9:0]  q8[$];
  logic [2:0]  q1[$];
  logic [17:0] q16[$];
  int          done8_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: compare every done pulse against the head of its queue.
  always @(negedge clk) begin
    if (done8) begin
      done8_cnt++;
      if (q8.size() == 0) check("w8_unexpected_done", 32'd1, 32'd0);
      else check("w8_result", {22'd0, cout8, ovf8, sum8}, {22'd0, q8.pop_front()});
      check("w8_busy_with_done", {31'd0, busy8}, 32'd0);
    end
    if (done1) begin
      if (q1.size() == 0) check("w1_unexpected_done", 32'd1, 32'd0);
      else check("w1_result", {29'd0, cout1, ovf1, sum1}, {29'd0, q1.pop_front()});
    end
    if (done16) begin
      if (q16.size() == 0) check("w16_unexpected_done", 32'd1, 32'd0);
      else check("w16_result", {14'd0, cout16, ovf16, sum16}, {14'd0, q16.pop_front()});
    end
  end

  // One WIDTH=8 operation; n counts edges with the start-sampling edge as 1.
  task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y,
                     input logic [9:0] exp);
    int n, nb;
    q8.push_back(exp);
    @(negedge clk); start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
    @(posedge clk); #1; start8 = 1'b0; n = 1; nb = busy8;
    while (!done8 && n < 40) begin
      @(posedge clk); #1; n++; nb += busy8;
    end
    check("w8_latency", n, 32'd9);
    check("w8_busy_cycles", nb, 32'd8);
    @(negedge clk);
  endtask

  task automatic op1(input logic m, input logic x, input logic y, input logic [2:0] exp);
    int n;
    q1.push_back(exp);
    @(negedge clk); start1 = 1'b1; mode1 = m; a1 = x; b1 = y;
    @(posedge clk); #1; start1 = 1'b0; n = 1;
    while (!done1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("w1_latency", n, 32'd2);
    @(negedge clk);
  endtask

  task automatic op16(input logic m, input logic [15:0] x, input logic [15:0] y,
                      input logic [17:0] exp);
    int n;
    q16.push_back(exp);
    @(negedge clk); start16 = 1'b1; mode16 = m; a16 = x; b16 = y;
    @(posedge clk); #1; start16 = 1'b0; n = 1;
    while (!done16 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("w16_latency", n, 32'd17);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, cnt0;
    // Reset state
    #12;
    check("reset_outputs", {22'd0, busy8, done8, cout8, ovf8, sum8}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed WIDTH=8 vectors: exp = {cout, overflow, sum}
    op8(1'b0, 8'h5A, 8'h3C, {1'b0, 1'b1, 8'h96});
    op8(1'b1, 8'h10, 8'h20, {1'b0, 1'b0, 8'hF0});
    op8(1'b1, 8'h80, 8'h01, {1'b1, 1'b1, 8'h7F});
    op8(1'b0, 8'hFF, 8'h01, {1'b1, 1'b0, 8'h00});
    op8(1'b1, 8'h33, 8'h33, {1'b1, 1'b0, 8'h00});

    // Start re-pulsed during RUN with other operands is ignored
    q8.push_back({1'b0, 1'b0, 8'h46});
    @(negedge clk); start8 = 1'b1; mode8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1; start8 = 1'b1; mode8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
    @(posedge clk); #1; start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    check("w8_repulse_done_seen", {31'd0, done8}, 32'd1);
    repeat (12) @(negedge clk);

    // Start held through DONE: back-to-back with 9-edge spacing
    q8.push_back({1'b0, 1'b0, 8'h03});
    q8.push_back({1'b1, 1'b0, 8'h02});
    @(negedge clk); start8 = 1'b1; mode8 = 1'b0; a8 = 8'h01; b8 = 8'h02;
    @(posedge clk); #1; mode8 = 1'b1; a8 = 8'h05; b8 = 8'h03; n = 1;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    check("w8_b2b_first_latency", n, 32'd9);
    @(posedge clk); #1; start8 = 1'b0; n2 = n + 1;
    while (!done8 && n2 < 60) begin @(posedge clk); #1; n2++; end
    check("w8_b2b_spacing", n2 - n, 32'd9);
    repeat (12) @(negedge clk);

    // Asynchronous reset at bit 4 aborts without a done
    cnt0 = done8_cnt;
    @(negedge clk); start8 = 1'b1; mode8 = 1'b0; a8 = 8'h5A; b8 = 8'h3C;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    check("async_reset_outputs", {22'd0, busy8, done8, cout8, ovf8, sum8}, 32'd0);
    repeat (2) @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", done8_cnt, cnt0);
    op8(1'b0, 8'h21, 8'h43, {1'b0, 1'b0, 8'h64});

    // Parameter sweep
    op1(1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0});
    op1(1'b1, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1});
    op16(1'b0, 16'h7FFF, 16'h0001, {1'b0, 1'b1, 16'h8000});
    op16(1'b1, 16'h1234, 16'h1234, {1'b1, 1'b0, 16'h0000});

    repeat (4) @(negedge clk);
    check("queues_drained", q8.size() + q1.size() + q16.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
